msg_header_sequencer: RTL and testbench

Multi-channel message header generator for the Arduino messaging send path. On a Start request it emits an 8- or 10-byte header (sync word, total byte count, per-channel message ID, per-channel sequence number, optional header checksum) as a valid/ready byte stream. It maintains an independent auto-incrementing sequence counter per channel. It sits ahead of the payload multiplexer and serial transmitter, which follow the header with the data bytes.

---
 rtl/msg_header_sequencer_pkg.sv | 23 ++
 rtl/msg_header_sequencer_if.sv | 37 +++
 rtl/msg_header_sequencer_seq_counter_bank.sv | 38 +++
 rtl/msg_header_sequencer.sv | 171 +++++++++++++++++
 tb/tb_msg_header_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_header_sequencer_pkg.sv
// msg_pkg: shared types and constants for the message header sequencer.
//   state_e          - sequencer FSM states
//   HEADER_BASE_LEN  - header length without checksum (bytes)
//   CHECKSUM_LEN     - length of the optional header checksum (bytes)
//   SYNC_WORD        - default sync word
//   chan_w()         - width of a channel index for a given channel count
package msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int HEADER_BASE_LEN = 8;
  localparam int CHECKSUM_LEN    = 2;
  localparam logic [15:0] SYNC_WORD = 16'h1234;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msg_header_sequencer_if.sv
// msg_header_sequencer_if: request + byte-stream bundle of the header sequencer.
//   Request side : start, channel, data_byte_count
//   Stream side  : byte_valid, byte_ready, header_byte, last_byte
//   Status       : busy, msg_byte_count, seq_used, done, error
// Modports: master = requester/downstream (the user), slave = the sequencer.
interface msg_header_sequencer_if #(
  parameter int NumChannels = 4
);
  localparam int ChanW = msg_pkg::chan_w(NumChannels);

  logic             start;
  logic [ChanW-1:0] channel;
  logic [15:0]      data_byte_count;
  logic             byte_ready;

  logic             busy;
  logic             byte_valid;
  logic [7:0]       header_byte;
  logic             last_byte;
  logic [15:0]      msg_byte_count;
  logic [15:0]      seq_used;
  logic             done;
  logic             error;

  modport master (
    output start, channel, data_byte_count, byte_ready,
    input  busy, byte_valid, header_byte, last_byte,
           msg_byte_count, seq_used, done, error
  );

  modport slave (
    input  start, channel, data_byte_count, byte_ready,
    output busy, byte_valid, header_byte, last_byte,
           msg_byte_count, seq_used, done, error
  );

endinterface

// File: rtl/msg_header_sequencer_seq_counter_bank.sv
// seq_counter_bank: one 16-bit wrapping sequence counter per channel.
//   clk_i, rst_i  - clock, synchronous active-high reset (clears all counters)
//   rd_chan_i     - channel whose counter appears on rd_count_o
//   inc_i         - increment strobe for channel inc_chan_i
//   inc_chan_i    - channel to increment
//   rd_count_o    - counter value of rd_chan_i (0 for an out-of-range channel)
module seq_counter_bank #(
  parameter int NumChannels = 4,
  parameter int ChanW       = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ChanW-1:0] rd_chan_i,
  input  logic             inc_i,
  input  logic [ChanW-1:0] inc_chan_i,
  output logic [15:0]      rd_count_o
);

  logic [15:0] cnt_q [NumChannels];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumChannels; i++) cnt_q[i] <= '0;
    end else if (inc_i) begin
      for (int i = 0; i < NumChannels; i++) begin
        if (int'(inc_chan_i) == i) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    rd_count_o = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (int'(rd_chan_i) == i) rd_count_o = cnt_q[i];
    end
  end

endmodule

// File: rtl/msg_header_sequencer.sv
// msg_header_sequencer: emits an 8-byte (or 10-byte with checksum) message
// header as a valid/ready byte stream and keeps a sequence counter per channel.
//   clk_i  - system clock, rising edge
//   rst_i  - synchronous active-high reset
//   bus    - msg_header_sequencer_if.slave (request, byte stream, status)
// Byte order: sync, total count, ID, sequence, [checksum]; each 16-bit field
// is sent low byte first.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for Start; validates channel and byte count
// LOAD    | one cycle: latch count, ID, sequence number and checksum
// SEND    | stream header bytes, one per valid/ready handshake
module msg_header_sequencer
  import msg_pkg::*;
#(
  parameter int          NumChannels    = 4,
  parameter logic [15:0] SyncWord       = SYNC_WORD,
  parameter logic [15:0] IdBase         = 16'h0001,
  parameter bit          ChecksumEnable = 1'b0
) (
  input logic                   clk_i,
  input logic                   rst_i,
  msg_header_sequencer_if.slave bus
);

  localparam int          ChanW        = chan_w(NumChannels);
  localparam int          HeaderLenInt = HEADER_BASE_LEN + (ChecksumEnable ? CHECKSUM_LEN : 0);
  localparam logic [15:0] HeaderLen    = 16'(HeaderLenInt);
  localparam logic [15:0] MaxDataBytes = 16'hFFFF - HeaderLen;
  localparam logic [3:0]  LastIdx      = 4'(HeaderLenInt - 1);

  state_e           state_q, state_d;
  logic [ChanW-1:0] chan_q, chan_d;
  logic [15:0]      dbc_q, dbc_d;
  logic [3:0]       idx_q, idx_d;
  logic [15:0]      msg_cnt_q, msg_cnt_d;
  logic [15:0]      id_q, id_d;
  logic [15:0]      seq_q, seq_d;
  logic [15:0]      cks_q, cks_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             req_ok;
  logic             handshake;
  logic             last;
  logic             inc;
  logic [15:0]      cnt_rd;
  logic [7:0]       hdr_byte;

  seq_counter_bank #(
    .NumChannels (NumChannels),
    .ChanW       (ChanW)
  ) u_counters (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_chan_i  (chan_q),
    .inc_i      (inc),
    .inc_chan_i (chan_q),
    .rd_count_o (cnt_rd)
  );

  // Reject requests that would overflow the 16-bit total byte count.
  assign req_ok    = (int'(bus.channel) < NumChannels) && (bus.data_byte_count <= MaxDataBytes);
  assign handshake = (state_q == ST_SEND) && bus.byte_ready;
  assign last      = (idx_q == LastIdx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      chan_q    <= '0;
      dbc_q     <= '0;
      idx_q     <= '0;
      msg_cnt_q <= '0;
      id_q      <= '0;
      seq_q     <= '0;
      cks_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      dbc_q     <= dbc_d;
      idx_q     <= idx_d;
      msg_cnt_q <= msg_cnt_d;
      id_q      <= id_d;
      seq_q     <= seq_d;
      cks_q     <= cks_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    dbc_d     = dbc_q;
    idx_d     = idx_q;
    msg_cnt_d = msg_cnt_q;
    id_d      = id_q;
    seq_d     = seq_q;
    cks_d     = cks_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (req_ok) begin
            chan_d  = bus.channel;
            dbc_d   = bus.data_byte_count;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        msg_cnt_d = HeaderLen + dbc_q;
        id_d      = IdBase + 16'(chan_q);
        seq_d     = cnt_rd;
        cks_d     = SyncWord + msg_cnt_d + id_d + seq_d;
        idx_d     = '0;
        state_d   = ST_SEND;
      end

      ST_SEND: begin
        if (handshake) begin
          if (last) begin
            inc     = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q)
      4'd0:    hdr_byte = SyncWord[7:0];
      4'd1:    hdr_byte = SyncWord[15:8];
      4'd2:    hdr_byte = msg_cnt_q[7:0];
      4'd3:    hdr_byte = msg_cnt_q[15:8];
      4'd4:    hdr_byte = id_q[7:0];
      4'd5:    hdr_byte = id_q[15:8];
      4'd6:    hdr_byte = seq_q[7:0];
      4'd7:    hdr_byte = seq_q[15:8];
      4'd8:    hdr_byte = cks_q[7:0];
      4'd9:    hdr_byte = cks_q[15:8];
      default: hdr_byte = 8'h00;
    endcase
  end

  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.byte_valid     = (state_q == ST_SEND);
  assign bus.last_byte      = (state_q == ST_SEND) && last;
  assign bus.header_byte    = (state_q == ST_SEND) ? hdr_byte : 8'h00;
  assign bus.msg_byte_count = msg_cnt_q;
  assign bus.seq_used       = seq_q;
  assign bus.done           = done_q;
  assign bus.error          = err_q;

endmodule

// File: tb/tb_msg_header_sequencer.sv
// Directed bench for msg_header_sequencer: instance 0 uses the default header
// (IdBase 0x0100), instance 1 appends the checksum (IdBase 0x0102, 5 channels).
module tb_msg_header_sequencer;

  logic clk;
  logic rst;

  msg_header_sequencer_if #(.NumChannels(4)) ifa ();
  msg_header_sequencer_if #(.NumChannels(5)) ifb ();

  msg_header_sequencer #(
    .NumChannels    (4),
    .IdBase         (16'h0100),
    .ChecksumEnable (1'b0)
  ) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  msg_header_sequencer #(
    .NumChannels    (5),
    .IdBase         (16'h0102),
    .ChecksumEnable (1'b1)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  logic        start_v [2];
  logic [2:0]  chan_v  [2];
  logic [15:0] dbc_v   [2];
  logic        rdy_v   [2];

  logic        bsy [2];
  logic        bv  [2];
  logic        lb  [2];
  logic        dn  [2];
  logic        er  [2];
  logic [7:0]  hb  [2];
  logic [15:0] mbc [2];
  logic [15:0] sq  [2];

  assign ifa.start           = start_v[0];
  assign ifa.channel         = chan_v[0][1:0];
  assign ifa.data_byte_count = dbc_v[0];
  assign ifa.byte_ready      = rdy_v[0];
  assign ifb.start           = start_v[1];
  assign ifb.channel         = chan_v[1];
  assign ifb.data_byte_count = dbc_v[1];
  assign ifb.byte_ready      = rdy_v[1];

  assign bsy[0] = ifa.busy;            assign bsy[1] = ifb.busy;
  assign bv[0]  = ifa.byte_valid;      assign bv[1]  = ifb.byte_valid;
  assign lb[0]  = ifa.last_byte;       assign lb[1]  = ifb.last_byte;
  assign dn[0]  = ifa.done;            assign dn[1]  = ifb.done;
  assign er[0]  = ifa.error;           assign er[1]  = ifb.error;
  assign hb[0]  = ifa.header_byte;     assign hb[1]  = ifb.header_byte;
  assign mbc[0] = ifa.msg_byte_count;  assign mbc[1] = ifb.msg_byte_count;
  assign sq[0]  = ifa.seq_used;        assign sq[1]  = ifb.seq_used;

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns with the DUT in LOAD.
  task automatic issue(input int s, input int ch, input logic [15:0] dbc);
    start_v[s] = 1'b1;
    chan_v[s]  = 3'(ch);
    dbc_v[s]   = dbc;
    tick();
    start_v[s] = 1'b0;
  endtask

  // Present a request that must be rejected; checks the Error pulse.
  task automatic reject(input int s, input int ch, input logic [15:0] dbc, input string tag);
    start_v[s] = 1'b1;
    chan_v[s]  = 3'(ch);
    dbc_v[s]   = dbc;
    tick();
    start_v[s] = 1'b0;
    check_eq({tag, "_err"}, 32'(er[s]), 32'd1);
    check_eq({tag, "_bv"},  32'(bv[s]), 32'd0);
    check_eq({tag, "_bsy"}, 32'(bsy[s]), 32'd0);
    tick();
    check_eq({tag, "_err_end"}, 32'(er[s]), 32'd0);
    check_eq({tag, "_bv2"},     32'(bv[s]), 32'd0);
  endtask

  // Collect n header bytes; exp holds byte i at bits [8*i +: 8]. With toggle,
  // byte_ready follows 1-0-0-1 over valid cycles. Returns one cycle after the
  // last handshake, where Done must be high.
  task automatic get_hdr(input int s, input logic [79:0] exp, input int n,
                         input bit toggle, input string tag);
    int idx  = 0;
    int cyc  = 0;
    int vcyc = 0;
    while (idx < n && cyc < 80) begin
      if (bv[s]) begin
        rdy_v[s] = toggle ? ((vcyc % 4 == 0) || (vcyc % 4 == 3)) : 1'b1;
        check_eq($sformatf("%s_byte%0d", tag, idx), 32'(hb[s]), 32'(exp[8*idx +: 8]));
        check_eq($sformatf("%s_last%0d", tag, idx), 32'(lb[s]), 32'(idx == n - 1));
        if (rdy_v[s]) idx++;
        vcyc++;
      end
      tick();
      cyc++;
    end
    rdy_v[s] = 1'b1;
    check_eq({tag, "_nbytes"}, 32'(idx), 32'(n));
    check_eq({tag, "_done"},   32'(dn[s]), 32'd1);
    check_eq({tag, "_busy"},   32'(bsy[s]), 32'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      chan_v[s]  = '0;
      dbc_v[s]   = '0;
      rdy_v[s]   = 1'b1;
    end
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst_busy",  32'(bsy[0]), 32'd0);
    check_eq("rst_valid", 32'(bv[0]),  32'd0);
    check_eq("rst_last",  32'(lb[0]),  32'd0);
    check_eq("rst_done",  32'(dn[0]),  32'd0);
    check_eq("rst_error", 32'(er[0]),  32'd0);
    check_eq("rst_hbyte", 32'(hb[0]),  32'd0);
    check_eq("rst_mbc",   32'(mbc[0]), 32'd0);
    check_eq("rst_seq",   32'(sq[0]),  32'd0);

    // ch2, 0x20 data bytes: 34 12 28 00 02 01 00 00
    issue(0, 2, 16'h0020);
    check_eq("load_busy",  32'(bsy[0]), 32'd1);
    check_eq("load_valid", 32'(bv[0]),  32'd0);
    tick();
    check_eq("send_valid", 32'(bv[0]),  32'd1);
    get_hdr(0, {16'h0000, 16'h0000, 16'h0102, 16'h0028, 16'h1234}, 8, 1'b0, "h1");
    check_eq("h1_mbc", 32'(mbc[0]), 32'h0028);
    check_eq("h1_seq", 32'(sq[0]),  32'h0000);
    tick();
    check_eq("h1_done_pulse", 32'(dn[0]), 32'd0);

    // Repeat on ch2 with stalls: sequence 1
    issue(0, 2, 16'h0020);
    get_hdr(0, {16'h0000, 16'h0001, 16'h0102, 16'h0028, 16'h1234}, 8, 1'b1, "h2");
    check_eq("h2_seq", 32'(sq[0]), 32'h0001);

    // ch1 untouched: sequence 0, ID 0x0101
    issue(0, 1, 16'h0020);
    get_hdr(0, {16'h0000, 16'h0000, 16'h0101, 16'h0028, 16'h1234}, 8, 1'b0, "h3");

    // Overflowing byte count rejected, ch2 counter keeps 2
    reject(0, 2, 16'hFFF8, "ovf_a");
    issue(0, 2, 16'h0020);
    get_hdr(0, {16'h0000, 16'h0002, 16'h0102, 16'h0028, 16'h1234}, 8, 1'b0, "h4");

    // Largest legal byte count: total 0xFFFF
    issue(0, 3, 16'hFFF7);
    get_hdr(0, {16'h0000, 16'h0000, 16'h0103, 16'hFFFF, 16'h1234}, 8, 1'b0, "h5");
    check_eq("h5_mbc", 32'(mbc[0]), 32'hFFFF);

    // Reset while the 4th byte is presented
    issue(0, 2, 16'h0020);
    w = 0;
    while (!bv[0] && w < 10) begin tick(); w++; end
    check_eq("rs_valid", 32'(bv[0]), 32'd1);
    tick();
    tick();
    tick();
    check_eq("rs_byte3", 32'(hb[0]), 32'h00);
    check_eq("rs_last3", 32'(lb[0]), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rs_abort_valid", 32'(bv[0]),  32'd0);
    check_eq("rs_abort_done",  32'(dn[0]),  32'd0);
    check_eq("rs_abort_busy",  32'(bsy[0]), 32'd0);
    tick();
    check_eq("rs_no_done", 32'(dn[0]), 32'd0);
    issue(0, 2, 16'h0020);
    get_hdr(0, {16'h0000, 16'h0000, 16'h0102, 16'h0028, 16'h1234}, 8, 1'b0, "h6");

    // Start held high: back-to-back on ch0, sequences 0,1,2
    start_v[0] = 1'b1;
    chan_v[0]  = 3'd0;
    dbc_v[0]   = 16'h0020;
    tick();
    get_hdr(0, {16'h0000, 16'h0000, 16'h0100, 16'h0028, 16'h1234}, 8, 1'b0, "bb0");
    check_eq("bb0_no_err", 32'(er[0]), 32'd0);
    check_eq("bb0_gap1",   32'(bv[0]), 32'd0);
    tick();
    check_eq("bb0_gap2",   32'(bv[0]),  32'd0);
    check_eq("bb0_load",   32'(bsy[0]), 32'd1);
    tick();
    check_eq("bb1_valid",  32'(bv[0]),  32'd1);
    get_hdr(0, {16'h0000, 16'h0001, 16'h0100, 16'h0028, 16'h1234}, 8, 1'b0, "bb1");
    tick();
    tick();
    check_eq("bb2_valid",  32'(bv[0]),  32'd1);
    get_hdr(0, {16'h0000, 16'h0002, 16'h0100, 16'h0028, 16'h1234}, 8, 1'b0, "bb2");
    start_v[0] = 1'b0;
    check_eq("bb2_no_err", 32'(er[0]), 32'd0);
    tick();
    check_eq("bb_idle", 32'(bsy[0]), 32'd0);

    // Checksum variant: ch0 -> count 0x002A, Cks 0x1360, 10 bytes
    issue(1, 0, 16'h0020);
    get_hdr(1, {16'h1360, 16'h0000, 16'h0102, 16'h002A, 16'h1234}, 10, 1'b0, "ck1");
    check_eq("ck1_mbc", 32'(mbc[1]), 32'h002A);
    reject(1, 5, 16'h0020, "chan_b");
    reject(1, 0, 16'hFFF6, "ovf_b");
    issue(1, 0, 16'h0020);
    get_hdr(1, {16'h1361, 16'h0001, 16'h0102, 16'h002A, 16'h1234}, 10, 1'b1, "ck2");
    check_eq("ck2_seq", 32'(sq[1]), 32'h0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
